// File: rtl/dpi_timing_generator.sv
// dpi_timing_generator
//   Produces the PAL-rate DPI raster: displayEnabled, active-low hSync/vSync,
//   the active-area coordinates fieldLine/fieldLineDot, field parity and
//   line/field start pulses. Everything advances on the one-in-six pixel enable.
//
// Ports
//   pixelClockX6     in   system clock, 6x pixel rate
//   reset            in   synchronous, active-high
//   pixelClockX1_en  in   pixel enable, one pixelClockX6 cycle in six
//   displayEnabled   out  high on active dots of active lines
//   hSync            out  active-low horizontal sync
//   vSync            out  active-low vertical sync (whole lines)
//   fieldLine        out  active line index, 0 outside the active lines
//   fieldLineDot     out  active dot index, 0 outside the active area
//   fieldParity      out  0 = even field, 1 = odd (one extra back-porch line)
//   lineStart        out  one-tick pulse at dot 0 of every line
//   fieldStart       out  one-tick pulse at dot 0, line 0 of every field
module dpi_timing_generator #(
  parameter int H_ACTIVE   = 720,
  parameter int H_FP       = 12,
  parameter int H_SYNC     = 64,
  parameter int H_BP       = 68,
  parameter int V_ACTIVE   = 288,
  parameter int V_FP       = 2,
  parameter int V_SYNC     = 3,
  parameter int V_BP       = 19,
  parameter int INTERLACED = 1
) (
  input  logic       pixelClockX6,
  input  logic       reset,
  input  logic       pixelClockX1_en,
  output logic       displayEnabled,
  output logic       hSync,
  output logic       vSync,
  output logic [9:0] fieldLine,
  output logic [9:0] fieldLineDot,
  output logic       fieldParity,
  output logic       lineStart,
  output logic       fieldStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST_EVEN  = 10'(V_TOTAL - 1);
  // Odd fields of an interlaced raster carry one extra back-porch line.
  localparam logic [9:0] V_LAST_ODD   = (INTERLACED != 0) ? 10'(V_TOTAL) : 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT        = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT        = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] hPos;
  logic [9:0] vPos;
  logic       oddField;

  logic lineEnd_p0;
  logic fieldEnd_p0;
  logic activeH_p0;
  logic activeV_p0;
  logic hSyncN_p0;
  logic vSyncN_p0;

  // Stage p0: decode of the current raster position
  always_comb begin
    lineEnd_p0  = (hPos == H_LAST);
    fieldEnd_p0 = lineEnd_p0 && (vPos == (oddField ? V_LAST_ODD : V_LAST_EVEN));
    activeH_p0  = (hPos < H_ACT);
    activeV_p0  = (vPos < V_ACT);
    hSyncN_p0   = !((hPos >= H_SYNC_START) && (hPos < H_SYNC_END));
    vSyncN_p0   = !((vPos >= V_SYNC_START) && (vPos < V_SYNC_END));
  end

  // Stage p1: position counters advance and decodes are registered together
  always_ff @(posedge pixelClockX6) begin
    if (reset) begin
      hPos           <= '0;
      vPos           <= '0;
      oddField       <= 1'b0;
      displayEnabled <= 1'b0;
      hSync          <= 1'b1;
      vSync          <= 1'b1;
      fieldLine      <= '0;
      fieldLineDot   <= '0;
      fieldParity    <= 1'b0;
      lineStart      <= 1'b0;
      fieldStart     <= 1'b0;
    end else if (pixelClockX1_en) begin
      if (lineEnd_p0) begin
        hPos <= '0;
        if (fieldEnd_p0) begin
          vPos     <= '0;
          oddField <= (INTERLACED != 0) ? ~oddField : 1'b0;
        end else begin
          vPos <= vPos + 10'd1;
        end
      end else begin
        hPos <= hPos + 10'd1;
      end

      displayEnabled <= activeH_p0 && activeV_p0;
      hSync          <= hSyncN_p0;
      vSync          <= vSyncN_p0;
      fieldLineDot   <= (activeH_p0 && activeV_p0) ? hPos : '0;
      fieldLine      <= activeV_p0 ? vPos : '0;
      // Parity is registered alongside the position so it flips with fieldStart.
      fieldParity    <= oddField;
      lineStart      <= (hPos == 10'd0);
      fieldStart     <= (hPos == 10'd0) && (vPos == 10'd0);
    end
  end

endmodule

// File: tb/tb_dpi_timing_generator.sv
module tb_dpi_timing_generator;

  logic clk;
  logic reset;
  logic en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dut 0: full PAL raster; dut 1: small interlaced raster; dut 2: small progressive
  logic       de [3];
  logic       hs [3];
  logic       vs [3];
  logic [9:0] fl [3];
  logic [9:0] fd [3];
  logic       fp [3];
  logic       ls [3];
  logic       fs [3];
  logic [25:0] obs [3];

  dpi_timing_generator dutA (
    .pixelClockX6(clk), .reset(reset), .pixelClockX1_en(en),
    .displayEnabled(de[0]), .hSync(hs[0]), .vSync(vs[0]), .fieldLine(fl[0]),
    .fieldLineDot(fd[0]), .fieldParity(fp[0]), .lineStart(ls[0]), .fieldStart(fs[0])
  );

  dpi_timing_generator #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .INTERLACED(1)
  ) dutB (
    .pixelClockX6(clk), .reset(reset), .pixelClockX1_en(en),
    .displayEnabled(de[1]), .hSync(hs[1]), .vSync(vs[1]), .fieldLine(fl[1]),
    .fieldLineDot(fd[1]), .fieldParity(fp[1]), .lineStart(ls[1]), .fieldStart(fs[1])
  );

  dpi_timing_generator #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .INTERLACED(0)
  ) dutC (
    .pixelClockX6(clk), .reset(reset), .pixelClockX1_en(en),
    .displayEnabled(de[2]), .hSync(hs[2]), .vSync(vs[2]), .fieldLine(fl[2]),
    .fieldLineDot(fd[2]), .fieldParity(fp[2]), .lineStart(ls[2]), .fieldStart(fs[2])
  );

  for (genvar g = 0; g < 3; g++) begin : g_pack
    assign obs[g] = {de[g], hs[g], vs[g], fl[g], fd[g], fp[g], ls[g], fs[g]};
  end

  localparam logic [25:0] RESETV = {1'b0, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0};

  int nTests = 0;
  int nFail  = 0;
  int k      = 0;   // enable ticks taken since reset released

  // Reference: the raster as a closed-form function of the tick index n.
  function automatic logic [25:0] model(input int d, input int n);
    int ha, hf, hsw, hb, va, vf, vsw, vb, il, ht, vt, t, par, line, dot;
    logic eDe, eHs, eVs, eLs, eFs;
    int eFl, eFd;
    if (d == 0) begin
      ha = 720; hf = 12; hsw = 64; hb = 68; va = 288; vf = 2; vsw = 3; vb = 19; il = 1;
    end else begin
      ha = 8; hf = 2; hsw = 3; hb = 3; va = 6; vf = 1; vsw = 2; vb = 2; il = (d == 1) ? 1 : 0;
    end
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    t  = (il != 0) ? n % ((2 * vt + 1) * ht) : n % (vt * ht);
    par = 0;
    if (il != 0 && t >= vt * ht) begin
      par = 1;
      t   = t - vt * ht;
    end
    line = t / ht;
    dot  = t % ht;
    eDe = (dot < ha) && (line < va);
    eHs = !((dot >= ha + hf) && (dot < ha + hf + hsw));
    eVs = !((line >= va + vf) && (line < va + vf + vsw));
    eFl = (line < va) ? line : 0;
    eFd = eDe ? dot : 0;
    eLs = (dot == 0);
    eFs = (dot == 0) && (line == 0);
    return {eDe, eHs, eVs, 10'(eFl), 10'(eFd), 1'(par), eLs, eFs};
  endfunction

  function automatic logic [25:0] expv(input int d);
    return (k == 0) ? RESETV : model(d, k - 1);
  endfunction

  task automatic step(input logic e);
    en = e;
    @(posedge clk);
    #1;
    if (reset) k = 0;
    else if (e) k++;
  endtask

  task automatic doReset();
    reset = 1'b1;
    step(1'b0);
    step(1'b1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(c[0]);   // enable high on alternate cycles: reset must win
      for (int d = 0; d < 3; d++) begin
        nTests++;
        if (obs[d] !== RESETV) begin
          nFail++;
          $display("FAIL reset_hold dut%0d: got %h, want %h", d, obs[d], RESETV);
        end
      end
    end
    reset = 1'b0;
    step(1'b0);
    for (int d = 0; d < 3; d++) begin
      nTests++;
      if (obs[d] !== RESETV) begin
        nFail++;
        $display("FAIL reset_release dut%0d: got %h, want %h", d, obs[d], RESETV);
      end
    end
  endtask

  task automatic test_first_enable();
    step(1'b1);
    nTests++;
    if ({de[0], fs[0], ls[0], hs[0], vs[0]} !== 5'b11111) begin
      nFail++;
      $display("FAIL first_enable: got de/fs/ls/hs/vs=%b, want 11111",
               {de[0], fs[0], ls[0], hs[0], vs[0]});
    end
    for (int c = 0; c < 5; c++) begin
      step(1'b0);
      for (int d = 0; d < 3; d++) begin
        nTests++;
        if (obs[d] !== expv(d)) begin
          nFail++;
          $display("FAIL first_hold dut%0d: got %h, want %h", d, obs[d], expv(d));
        end
      end
    end
    step(1'b1);
    nTests++;
    if (ls[0] !== 1'b0 || fs[0] !== 1'b0 || fd[0] !== 10'd1) begin
      nFail++;
      $display("FAIL second_tick: got ls=%b fs=%b dot=%0d, want 0 0 1", ls[0], fs[0], fd[0]);
    end
  endtask

  task automatic test_line();
    int deCount, hsFirst, hsCount, lsPrev, lsPeriod, idx;
    deCount = 0; hsFirst = -1; hsCount = 0; lsPrev = -1; lsPeriod = -1;
    doReset();
    while (k < 865) begin
      step(1'b1);
      idx = k - 1;
      for (int d = 0; d < 3; d++) begin
        nTests++;
        if (obs[d] !== expv(d)) begin
          nFail++;
          $display("FAIL line_tick dut%0d idx%0d: got %h, want %h", d, idx, obs[d], expv(d));
        end
      end
      if (idx < 864) begin
        if (de[0]) deCount++;
        if (!hs[0]) begin
          if (hsFirst < 0) hsFirst = idx;
          hsCount++;
        end
      end
      if (ls[0]) begin
        if (lsPrev >= 0) lsPeriod = idx - lsPrev;
        lsPrev = idx;
      end
      if (idx == 719) begin
        nTests++;
        if (fd[0] !== 10'd719 || de[0] !== 1'b1) begin
          nFail++;
          $display("FAIL last_dot: got dot=%0d de=%b, want 719 1", fd[0], de[0]);
        end
      end
      if (idx == 720) begin
        nTests++;
        if (fd[0] !== 10'd0 || de[0] !== 1'b0) begin
          nFail++;
          $display("FAIL after_active: got dot=%0d de=%b, want 0 0", fd[0], de[0]);
        end
      end
      repeat ($urandom_range(0, 2)) step(1'b0);
    end
    nTests++;
    if (deCount != 720) begin nFail++; $display("FAIL de_count: got %0d, want 720", deCount); end
    nTests++;
    if (hsFirst != 732) begin nFail++; $display("FAIL hsync_start: got %0d, want 732", hsFirst); end
    nTests++;
    if (hsCount != 64) begin nFail++; $display("FAIL hsync_len: got %0d, want 64", hsCount); end
    nTests++;
    if (lsPeriod != 864) begin nFail++; $display("FAIL line_period: got %0d, want 864", lsPeriod); end
  endtask

  task automatic test_field();
    int fsB[$];
    int fsC[$];
    int vsFirst, vsCount, actLines, idx, i1, i2;
    logic parSeen;
    vsFirst = -1; vsCount = 0; actLines = 0; parSeen = 1'b0;
    doReset();
    while (k < 800) begin
      step(1'b1);
      idx = k - 1;
      for (int d = 0; d < 3; d++) begin
        nTests++;
        if (obs[d] !== expv(d)) begin
          nFail++;
          $display("FAIL field_tick dut%0d idx%0d: got %h, want %h", d, idx, obs[d], expv(d));
        end
      end
      if (fs[1]) fsB.push_back(idx);
      if (fs[2]) fsC.push_back(idx);
      if (fp[2]) parSeen = 1'b1;
      if (idx < 176) begin
        if (!vs[2]) begin
          if (vsFirst < 0) vsFirst = idx;
          vsCount++;
        end
        if (ls[2] && de[2]) actLines++;
      end
      repeat ($urandom_range(0, 1)) step(1'b0);
    end
    nTests++;
    if (fsB.size() < 4) begin
      nFail++;
      $display("FAIL fs_count_b: got %0d, want >=4", fsB.size());
    end else begin
      i1 = fsB[1] - fsB[0];
      i2 = fsB[2] - fsB[1];
      if (!((i1 == 176 && i2 == 192) || (i1 == 192 && i2 == 176)) || (fsB[3] - fsB[2]) != i1) begin
        nFail++;
        $display("FAIL interlace_intervals: got %0d %0d %0d, want 176/192 alternating",
                 i1, i2, fsB[3] - fsB[2]);
      end
    end
    nTests++;
    if (fsC.size() < 4 || fsC[1] - fsC[0] != 176 || fsC[2] - fsC[1] != 176) begin
      nFail++;
      $display("FAIL progressive_intervals: got count %0d, want 176-tick fields", fsC.size());
    end
    nTests++;
    if (parSeen !== 1'b0) begin nFail++; $display("FAIL progressive_parity: got 1, want 0"); end
    nTests++;
    if (vsFirst != 112 || vsCount != 32) begin
      nFail++;
      $display("FAIL vsync: got start %0d len %0d, want 112 32", vsFirst, vsCount);
    end
    nTests++;
    if (actLines != 6) begin nFail++; $display("FAIL active_lines: got %0d, want 6", actLines); end
  endtask

  task automatic test_freeze();
    logic [25:0] held [3];
    doReset();
    repeat (300) step(1'b1);
    for (int d = 0; d < 3; d++) held[d] = obs[d];
    for (int c = 0; c < 100; c++) begin
      step(1'b0);
      for (int d = 0; d < 3; d++) begin
        nTests++;
        if (obs[d] !== held[d] || obs[d] !== expv(d)) begin
          nFail++;
          $display("FAIL freeze dut%0d cyc%0d: got %h, want %h", d, c, obs[d], held[d]);
        end
      end
    end
    step(1'b1);
    for (int d = 0; d < 3; d++) begin
      nTests++;
      if (obs[d] !== expv(d)) begin
        nFail++;
        $display("FAIL resume dut%0d: got %h, want %h", d, obs[d], expv(d));
      end
    end
  endtask

  task automatic test_reset_mid();
    int budget;
    budget = 0;
    while (!(fl[1] == 10'd3 && fd[1] == 10'd5 && fp[1] == 1'b1) && budget < 2000) begin
      step(1'b1);
      budget++;
    end
    nTests++;
    if (budget >= 2000) begin
      nFail++;
      $display("FAIL reset_mid_reach: got timeout, want line 3 dot 5 odd field");
    end
    reset = 1'b1;
    step(1'b1);
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      nTests++;
      if (obs[d] !== RESETV) begin
        nFail++;
        $display("FAIL reset_mid dut%0d: got %h, want %h", d, obs[d], RESETV);
      end
    end
    step(1'b1);
    for (int d = 0; d < 3; d++) begin
      nTests++;
      if (obs[d] !== model(d, 0)) begin
        nFail++;
        $display("FAIL restart dut%0d: got %h, want %h", d, obs[d], model(d, 0));
      end
    end
  endtask

  // Behavioural line tracker fed from the raster; starts right after a fieldStart.
  task automatic test_loopback();
    int trkLine, trkDot, fields;
    logic prevDe, newField;
    trkLine = 0; trkDot = 0; prevDe = 1'b0; newField = fs[1]; fields = 0;
    while (fields < 3 && k < 1500) begin
      if (de[1]) begin
        if (!prevDe) begin
          trkDot  = 0;
          trkLine = newField ? 0 : trkLine + 1;
          newField = 1'b0;
        end else begin
          trkDot++;
        end
        nTests++;
        if (fl[1] !== 10'(trkLine) || fd[1] !== 10'(trkDot)) begin
          nFail++;
          $display("FAIL loopback: got line %0d dot %0d, want line %0d dot %0d",
                   fl[1], fd[1], trkLine, trkDot);
        end
      end
      prevDe = de[1];
      step(1'b1);
      if (fs[1]) begin
        newField = 1'b1;
        fields++;
      end
      repeat ($urandom_range(0, 1)) step(1'b0);
    end
    nTests++;
    if (fields < 3) begin nFail++; $display("FAIL loopback_fields: got %0d, want 3", fields); end
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    test_reset();
    test_first_enable();
    test_line();
    test_field();
    test_freeze();
    test_reset_mid();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/dpi_timing_generator.md
# dpi_timing_generator

Generates the PAL-rate DPI raster timing (displayEnabled, hSync, vSync) plus the matching dot/line coordinates for the 720x288-per-field active area. It is the transmit-side counterpart of the field line/dot tracker: looped back into the tracker, the tracker's fieldLine/fieldLineDot must equal this block's outputs. It runs on the x6 pixel clock with a one-in-six pixel enable and feeds the video-through path and test-pattern sources.

## Interface
- H_ACTIVE, 720, active dots per line
- H_FP, 12, horizontal front porch (dots)
- H_SYNC, 64, hSync width (dots)
- H_BP, 68, horizontal back porch (dots); line total 864
- V_ACTIVE, 288, active lines per field
- V_FP, 2, vertical front porch (lines)
- V_SYNC, 3, vSync width (lines)
- V_BP, 19, vertical back porch (lines); field total 312
- INTERLACED, 1, 1: odd fields get one extra back-porch line (312/313 alternating, 625 per frame)
- pixelClockX6  input  1  system clock, 6x pixel rate
- reset  input  1  synchronous, active-high
- pixelClockX1_en  input  1  pixel enable, one pixelClockX6 cycle in six
- displayEnabled  output  1  high during active dots of active lines
- hSync  output  1  active-low horizontal sync
- vSync  output  1  active-low vertical sync
- fieldLine  output  10  active line index 0..287
- fieldLineDot  output  10  active dot index 0..719
- fieldParity  output  1  0 = even field (312 lines), 1 = odd field
- lineStart  output  1  one-tick pulse at dot position 0 of every line
- fieldStart  output  1  one-tick pulse at dot 0, line 0 of every field

## Operation
- Internal counters: hPos 0..863, vPos 0..vTotal-1; vTotal = 312, or 313 when INTERLACED and fieldParity=1.
- All state advances only on pixelClockX1_en; with enable low every register holds.
- Per tick: hPos+1; at hPos=863, hPos→0 and vPos+1; at vPos=vTotal-1 and hPos=863, vPos→0 and fieldParity toggles (when INTERLACED=0 parity stays 0).
- Registered decodes of the current position (hPos, vPos):
  - displayEnabled = hPos<H_ACTIVE and vPos<V_ACTIVE.
  - hSync = 0 for hPos in [732,796), else 1; generated on every line including blanking.
  - vSync = 0 for vPos in [290,293) across whole lines (from hPos 0 to 863), else 1.
  - fieldLineDot = hPos while displayEnabled, else 0.
  - fieldLine = vPos while vPos<V_ACTIVE, else 0.
  - lineStart = (hPos==0); fieldStart = (hPos==0 and vPos==0).
- Counter widths: hPos and vPos 10 bits; no wrap beyond totals, since comparisons use the == terminal value.

## Timing
- Reset (any pixelClockX6 edge, regardless of enable): hPos=0, vPos=0, fieldParity=0, displayEnabled=0, hSync=1, vSync=1, fieldLine=0, fieldLineDot=0, lineStart=0, fieldStart=0.
- Latency: outputs reflect position p one pixelClockX6 cycle after the enable tick that samples p. The first enable after reset release shows (0,0): displayEnabled=1, lineStart=1, fieldStart=1.
- Outputs change only on the cycle following an enable tick. Pulses last exactly one enable period (6 clocks).
- Reset asserted mid-line or mid-field: outputs take reset values on the next edge and the raster restarts at (0,0) with parity 0; there is no partial-line completion.
- Simultaneous reset and enable: reset wins.
- Line-end and field-end on the same tick: hPos, vPos and parity all update on that one tick.

## Test plan
- Reset, then a steady enable (1 in 6): after the first enable, displayEnabled=1, fieldStart=1, hSync=1, vSync=1; all outputs were at reset values before it.
- One line: displayEnabled high for 720 consecutive enables, fieldLineDot 0..719 then 0; hSync low for 64 enables starting 732 enables after lineStart; lineStart period 864 enables.
- One field: 288 active lines, fieldLine 0..287; vSync low for exactly 3x864 enables, starting 290x864 enables after fieldStart.
- INTERLACED=1: fieldStart intervals alternate 312x864 / 313x864 enables, fieldParity toggles at each fieldStart, 625 lines per frame. With INTERLACED=0, every field is 312 lines and parity stays 0.
- Enable held low for 100 clocks mid-line: all outputs frozen; resume continues from the same dot. Reset pulsed at line 150, dot 400: raster restarts at (0,0), parity 0.
- Loopback into the line tracker over 2 fields: the tracker's fieldLine/fieldLineDot equal this block's values on every displayEnabled tick.
